multi_cycle_controller: RTL

Multi-cycle control unit sequencing the MIPS datapath (PC, instruction memory, register file, ALU, data memory, PC/jump/branch muxes) through one instruction per 3–5 cycles. Decodes the latched instruction's opcode/funct. Drives every datapath mux select, write enable and the 3-bit ALU control, plus PC and IR load enables. Stalls on a data-memory ready handshake.

---
 rtl/multi_cycle_controller_pkg.sv | 60 ++++++
 rtl/multi_cycle_controller_if.sv | 44 ++++
 rtl/multi_cycle_controller_alu_op_decoder.sv | 37 +++
 rtl/multi_cycle_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_controller_pkg.sv
//----------------------------------------------------------------------
// multi_cycle_controller_pkg -- opcode/funct/ALU codes, states. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package multi_cycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    MEM_RD = 4'd4,
    MEM_WR = 4'd5,
    WB_R   = 4'd6,
    WB_I   = 4'd7,
    WB_LW  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ERR    = 4'd11
  } state_e;

  // Which family of ALU operation the current state asks for.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_ITYPE = 2'd3
  } alu_cls_e;

  function automatic logic is_alu_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_controller_if.sv
//----------------------------------------------------------------------
// multi_cycle_controller_if -- controller <-> datapath bundle. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface multi_cycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       reg_dst;
  logic       jal_reg;
  logic       pc_to_reg;
  logic       alu_src;
  logic       mem_to_reg;
  logic       jump_sel;
  logic       pc_jump;
  logic       pc_src;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [2:0] alu_cntrl;
  logic       instr_done;
  logic       illegal;

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, reg_dst, jal_reg, pc_to_reg, alu_src,
           mem_to_reg, jump_sel, pc_jump, pc_src, reg_write, mem_read,
           mem_write, alu_cntrl, instr_done, illegal
  );

  modport master (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, reg_dst, jal_reg, pc_to_reg, alu_src,
           mem_to_reg, jump_sel, pc_jump, pc_src, reg_write, mem_read,
           mem_write, alu_cntrl, instr_done, illegal
  );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_controller_alu_op_decoder.sv
//----------------------------------------------------------------------
// alu_op_decoder -- (state class, opcode, funct) to alu_cntrl. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module alu_op_decoder
  import multi_cycle_controller_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_cntrl_o
);

  always_comb begin
    alu_cntrl_o = ALU_ADD;
    case (cls_i)
      CLS_SUB: alu_cntrl_o = ALU_SUB;
      CLS_RTYPE: begin
        case (funct_i)
          FN_SUB:  alu_cntrl_o = ALU_SUB;
          FN_AND:  alu_cntrl_o = ALU_AND;
          FN_OR:   alu_cntrl_o = ALU_OR;
          FN_SLT:  alu_cntrl_o = ALU_SLT;
          default: alu_cntrl_o = ALU_ADD;
        endcase
      end
      CLS_ITYPE: begin
        if (opcode_i == OP_SLTI) alu_cntrl_o = ALU_SLT;
      end
      default: alu_cntrl_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
//----------------------------------------------------------------------
// multi_cycle_controller -- MIPS multi-cycle control FSM. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  multi_cycle_controller_if.slave   bus
);

  state_e     state_q, state_d;
  logic       illegal_q;
  alu_cls_e   alu_cls;
  logic [2:0] alu_cntrl;
  logic       pc_write, ir_write, reg_dst, jal_reg, pc_to_reg, alu_src;
  logic       mem_to_reg, jump_sel, pc_jump, pc_src, reg_write;
  logic       mem_read, mem_write;

  always_comb begin
    state_d    = state_q;
    alu_cls    = CLS_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    jal_reg    = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    jump_sel   = 1'b0;
    pc_jump    = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct == FN_JR)          state_d = JUMP;
            else if (is_alu_funct(bus.funct)) state_d = EXEC_R;
            else                              state_d = ERR;
          end
          OP_ADDI, OP_SLTI, OP_LW, OP_SW: state_d = EXEC_I;
          OP_BEQ:                         state_d = BRANCH;
          OP_J, OP_JAL:                   state_d = JUMP;
          default:                        state_d = ERR;
        endcase
      end
      EXEC_R: begin
        alu_cls = CLS_RTYPE;
        state_d = WB_R;
      end
      WB_R: begin
        alu_cls   = CLS_RTYPE;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = FETCH;
      end
      EXEC_I: begin
        alu_cls = CLS_ITYPE;
        alu_src = 1'b1;
        if (bus.opcode == OP_LW)      state_d = MEM_RD;
        else if (bus.opcode == OP_SW) state_d = MEM_WR;
        else                          state_d = WB_I;
      end
      WB_I: begin
        alu_cls   = CLS_ITYPE;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = FETCH;
      end
      MEM_RD: begin
        alu_src  = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = WB_LW;
      end
      WB_LW: begin
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
        // The store completes and retires in the ready cycle itself.
        if (bus.mem_ready) begin
          pc_write = 1'b1;
          state_d  = FETCH;
        end
      end
      BRANCH: begin
        alu_cls  = CLS_SUB;
        pc_write = 1'b1;
        pc_src   = bus.zero;
        state_d  = FETCH;
      end
      JUMP: begin
        pc_jump  = 1'b1;
        pc_write = 1'b1;
        jump_sel = (bus.opcode != OP_RTYPE);
        if (bus.opcode == OP_JAL) begin
          jal_reg   = 1'b1;
          pc_to_reg = 1'b1;
          reg_write = 1'b1;
        end
        state_d = FETCH;
      end
      ERR:     state_d = ERR;
      default: state_d = FETCH;
    endcase

    // Held in reset: everything quiet, ALU parked on ADD.
    if (!rst) begin
      alu_cls    = CLS_ADD;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      jal_reg    = 1'b0;
      pc_to_reg  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      jump_sel   = 1'b0;
      pc_jump    = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ERR) illegal_q <= 1'b1;
    end
  end

  alu_op_decoder u_alu_op_decoder (
    .cls_i       (alu_cls),
    .opcode_i    (bus.opcode),
    .funct_i     (bus.funct),
    .alu_cntrl_o (alu_cntrl)
  );

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.jal_reg    = jal_reg;
  assign bus.pc_to_reg  = pc_to_reg;
  assign bus.alu_src    = alu_src;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.jump_sel   = jump_sel;
  assign bus.pc_jump    = pc_jump;
  assign bus.pc_src     = pc_src;
  assign bus.reg_write  = reg_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.alu_cntrl  = alu_cntrl;
  assign bus.instr_done = pc_write;
  assign bus.illegal    = illegal_q & rst;

endmodule

`default_nettype wire
